// File: rtl/acl_tx_sched.sv
// Master-side ACL transmit scheduler: each master TX slot picks an ARQ retransmission,
// then round-robin data, then an overdue POLL. Optional build macro: ACL_RETX_LIMIT_EN.
module acl_tx_sched #(
  parameter int TPOLL_W = 16,
  parameter int RETX_W  = 4
) (
  input  logic               clk_6M,
  input  logic               rstz,
  input  logic               regi_isMaster,
  input  logic               ms_tslot_p,
  input  logic               connsnewmaster,
  input  logic               sco_reserved,
  input  logic [7:0]         regi_lt_active,
  input  logic [7:0]         regi_txdata_pend,
  input  logic [3:0]         regi_packet_type,
  input  logic [TPOLL_W-1:0] regi_tpoll,
  input  logic [RETX_W-1:0]  regi_max_retx,
  input  logic [7:0]         srcFLOW,
  input  logic [7:0]         dec_arqn,
  output logic [2:0]         ms_lt_addr,
  output logic               ms_txcmd_p,
  output logic [3:0]         txpktype,
  output logic [7:0]         poll_due,
  output logic               flush_p
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_ISSUE} state_t;
  localparam logic [3:0] PKT_POLL = 4'h1;

  state_t     state_q;
  logic [2:0] rr_q;
  logic [2:0] last_lt_q;
  logic       last_data_q;

  logic [7:0] act;
  logic       retx_ok, flush_hit, data_found, poll_found;
  logic [2:0] data_lt, poll_lt, scan_idx;
  logic       sel_valid, sel_data;
  logic [2:0] sel_lt, sel_rr;
  logic [3:0] sel_type;
  logic       issue_now, flush_now;

  // LT_ADDR 0 is the broadcast address and never scheduled here.
  assign act = regi_lt_active & 8'hFE;
  assign poll_due[0] = 1'b0;

  for (genvar g = 1; g < 8; g++) begin : g_lt
    logic [TPOLL_W-1:0] cnt_q;

    assign poll_due[g] = act[g] && (regi_tpoll != '0) && (cnt_q >= regi_tpoll);

    always_ff @(posedge clk_6M or negedge rstz) begin
      if (!rstz) begin
        cnt_q <= '0;
      end else if (connsnewmaster || !act[g] || (issue_now && sel_lt == 3'(g))) begin
        cnt_q <= '0;
      end else if (ms_tslot_p && cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

`ifdef ACL_RETX_LIMIT_EN
  logic [RETX_W-1:0] retry_q;

  // A flushed retransmission restarts the count even if data follows in the same slot.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      retry_q <= '0;
    end else if (connsnewmaster || flush_now) begin
      retry_q <= '0;
    end else if (issue_now) begin
      retry_q <= retx_ok ? retry_q + 1'b1 : '0;
    end
  end
`else
  logic unused_max_retx;
  assign unused_max_retx = ^regi_max_retx;
`endif

  // NOTE: every always_comb output gets a default before any branch, so no latch can form.
  always_comb begin
    retx_ok = last_data_q && !dec_arqn[last_lt_q] && act[last_lt_q];
`ifdef ACL_RETX_LIMIT_EN
    flush_hit = retx_ok && (regi_max_retx != '0) && (retry_q == regi_max_retx);
`else
    flush_hit = 1'b0;
`endif
    data_found = 1'b0;
    data_lt    = 3'd0;
    poll_found = 1'b0;
    poll_lt    = 3'd0;
    scan_idx   = rr_q;
    for (int k = 0; k < 7; k++) begin
      if (!data_found && act[scan_idx] && regi_txdata_pend[scan_idx] && srcFLOW[scan_idx]) begin
        data_found = 1'b1;
        data_lt    = scan_idx;
      end
      if (!poll_found && poll_due[scan_idx]) begin
        poll_found = 1'b1;
        poll_lt    = scan_idx;
      end
      scan_idx = (scan_idx == 3'd7) ? 3'd1 : scan_idx + 3'd1;
    end

    sel_valid = 1'b0;
    sel_data  = 1'b0;
    sel_lt    = last_lt_q;
    sel_type  = regi_packet_type;
    sel_rr    = rr_q;
    if (retx_ok && !flush_hit) begin
      sel_valid = 1'b1;
      sel_data  = 1'b1;
    end else if (data_found) begin
      sel_valid = 1'b1;
      sel_data  = 1'b1;
      sel_lt    = data_lt;
      sel_rr    = (data_lt == 3'd7) ? 3'd1 : data_lt + 3'd1;
    end else if (poll_found) begin
      sel_valid = 1'b1;
      sel_lt    = poll_lt;
      sel_type  = PKT_POLL;
    end
  end

  assign issue_now = (state_q == ST_ARB) && regi_isMaster && !connsnewmaster && sel_valid;
  assign flush_now = (state_q == ST_ARB) && regi_isMaster && !connsnewmaster && flush_hit;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state_q     <= ST_IDLE;
      ms_lt_addr  <= 3'd0;
      ms_txcmd_p  <= 1'b0;
      txpktype    <= 4'h0;
      flush_p     <= 1'b0;
      rr_q        <= 3'd1;
      last_lt_q   <= 3'd0;
      last_data_q <= 1'b0;
    end else begin
      ms_txcmd_p <= 1'b0;
      // flush_p is registered, so it lines up with the ms_txcmd_p of the same slot.
      flush_p    <= flush_now;
      if (connsnewmaster) begin
        state_q     <= ST_IDLE;
        rr_q        <= 3'd1;
        last_data_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (ms_tslot_p && regi_isMaster && !sco_reserved) state_q <= ST_ARB;
          end
          ST_ARB: begin
            state_q <= issue_now ? ST_ISSUE : ST_IDLE;
            if (flush_now) last_data_q <= 1'b0;
            if (issue_now) begin
              ms_lt_addr  <= sel_lt;
              txpktype    <= sel_type;
              ms_txcmd_p  <= 1'b1;
              last_lt_q   <= sel_lt;
              last_data_q <= sel_data;
              rr_q        <= sel_rr;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acl_tx_sched.sv
// Self-checking bench for acl_tx_sched: directed scenarios plus random slots, scored
// against a slot-level reference model through an expected-event queue.
module tb_acl_tx_sched;

  localparam int TPOLL_W = 3;
  localparam int RETX_W  = 4;
  localparam int CNT_MAX = (1 << TPOLL_W) - 1;

  logic               clk_6M = 1'b0;
  logic               rstz = 1'b0;
  logic               regi_isMaster = 1'b0;
  logic               ms_tslot_p = 1'b0;
  logic               connsnewmaster = 1'b0;
  logic               sco_reserved = 1'b0;
  logic [7:0]         regi_lt_active = 8'h00;
  logic [7:0]         regi_txdata_pend = 8'h00;
  logic [3:0]         regi_packet_type = 4'h0;
  logic [TPOLL_W-1:0] regi_tpoll = '0;
  logic [RETX_W-1:0]  regi_max_retx = '0;
  logic [7:0]         srcFLOW = 8'hFF;
  logic [7:0]         dec_arqn = 8'hFF;
  logic [2:0]         ms_lt_addr;
  logic               ms_txcmd_p;
  logic [3:0]         txpktype;
  logic [7:0]         poll_due;
  logic               flush_p;

  acl_tx_sched #(.TPOLL_W(TPOLL_W), .RETX_W(RETX_W)) dut (
    .clk_6M           (clk_6M),
    .rstz             (rstz),
    .regi_isMaster    (regi_isMaster),
    .ms_tslot_p       (ms_tslot_p),
    .connsnewmaster   (connsnewmaster),
    .sco_reserved     (sco_reserved),
    .regi_lt_active   (regi_lt_active),
    .regi_txdata_pend (regi_txdata_pend),
    .regi_packet_type (regi_packet_type),
    .regi_tpoll       (regi_tpoll),
    .regi_max_retx    (regi_max_retx),
    .srcFLOW          (srcFLOW),
    .dec_arqn         (dec_arqn),
    .ms_lt_addr       (ms_lt_addr),
    .ms_txcmd_p       (ms_txcmd_p),
    .txpktype         (txpktype),
    .poll_due         (poll_due),
    .flush_p          (flush_p)
  );

  always #5 clk_6M = ~clk_6M;

  int cyc = 0;
  always @(posedge clk_6M) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  typedef struct {
    int cyc;
    bit issue;
    int lt;
    int typ;
    bit flush;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state, advanced once per slot.
  int m_rr = 1;
  int m_last_lt = 0;
  bit m_last_data = 1'b0;
  int m_retry = 0;
  int m_cnt[8];
  int m_out_lt = 0;
  int m_out_type = 0;

  function automatic bit bit_of(input logic [7:0] v, input int n);
    return v[n[2:0]];
  endfunction

  function automatic bit m_due(input int n);
    return bit_of(regi_lt_active & 8'hFE, n) && (regi_tpoll != '0) && (m_cnt[n] >= int'(regi_tpoll));
  endfunction

  function automatic logic [7:0] m_due_vec();
    logic [7:0] v;
    v = 8'h00;
    for (int n = 1; n < 8; n++) v = v | (8'(m_due(n)) << n);
    return v;
  endfunction

  task automatic model_conn();
    m_rr = 1;
    m_last_data = 1'b0;
    m_retry = 0;
    for (int n = 0; n < 8; n++) m_cnt[n] = 0;
  endtask

  task automatic model_slot(input bit go);
    logic [7:0] act;
    bit issue, flush, retx, is_data;
    int lt, typ, n;
    exp_t e;
    act = regi_lt_active & 8'hFE;
    for (int i = 1; i < 8; i++)
      m_cnt[i] = bit_of(act, i) ? ((m_cnt[i] < CNT_MAX) ? m_cnt[i] + 1 : CNT_MAX) : 0;
    if (!go) return;
    issue = 1'b0; flush = 1'b0; is_data = 1'b0; lt = 0; typ = 0;
    retx = m_last_data && !bit_of(dec_arqn, m_last_lt) && bit_of(act, m_last_lt);
`ifdef ACL_RETX_LIMIT_EN
    if (retx && regi_max_retx != '0 && m_retry == int'(regi_max_retx)) begin
      flush = 1'b1; retx = 1'b0; m_last_data = 1'b0; m_retry = 0;
    end
`endif
    if (retx) begin
      issue = 1'b1; lt = m_last_lt; typ = int'(regi_packet_type); is_data = 1'b1;
      m_retry = (m_retry + 1) % (1 << RETX_W);
    end else begin
      for (int k = 0; k < 7; k++) begin
        n = (m_rr - 1 + k) % 7 + 1;
        if (!issue && bit_of(act, n) && bit_of(regi_txdata_pend, n) && bit_of(srcFLOW, n)) begin
          issue = 1'b1; lt = n; typ = int'(regi_packet_type); is_data = 1'b1;
        end
      end
      if (issue) begin
        m_rr = lt % 7 + 1;
        m_retry = 0;
      end else begin
        for (int k = 0; k < 7; k++) begin
          n = (m_rr - 1 + k) % 7 + 1;
          if (!issue && m_due(n)) begin
            issue = 1'b1; lt = n; typ = 1; is_data = 1'b0;
          end
        end
        if (issue) m_retry = 0;
      end
    end
    if (issue) begin
      m_last_lt = lt; m_last_data = is_data; m_cnt[lt] = 0;
      m_out_lt = lt; m_out_type = typ;
    end
    if (issue || flush) begin
      e.cyc = cyc + 2; e.issue = issue; e.lt = lt; e.typ = typ; e.flush = flush;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every DUT event is matched against the oldest expected event.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_6M);
      if (rstz) begin
        if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
          e = exp_q.pop_front();
          check("event_missing_at_cycle", 32'(cyc), 32'(e.cyc));
        end
        if (ms_txcmd_p || flush_p) begin
          if (exp_q.size() == 0) begin
            check("unexpected_event", {30'd0, ms_txcmd_p, flush_p}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("event_cycle", 32'(cyc), 32'(e.cyc));
            check("ms_txcmd_p", 32'(ms_txcmd_p), 32'(e.issue));
            if (e.issue) begin
              check("ms_lt_addr", 32'(ms_lt_addr), 32'(e.lt));
              check("txpktype", 32'(txpktype), 32'(e.typ));
            end
            check("flush_p", 32'(flush_p), 32'(e.flush));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_6M);
    #1;
  endtask

  task automatic do_conn();
    tick();
    connsnewmaster = 1'b1;
    model_conn();
    tick();
    connsnewmaster = 1'b0;
  endtask

  task automatic do_slot(input bit conn_arb, input bit drop_arb);
    bit go, saved_master;
    tick();
    ms_tslot_p = 1'b1;
    saved_master = regi_isMaster;
    go = regi_isMaster && !sco_reserved && !conn_arb && !drop_arb;
    model_slot(go);
    tick();
    ms_tslot_p = 1'b0;
    if (conn_arb) begin
      connsnewmaster = 1'b1;
      model_conn();
    end
    if (drop_arb) regi_isMaster = 1'b0;
    tick();
    connsnewmaster = 1'b0;
    regi_isMaster = saved_master;
    repeat (3) tick();
    check("poll_due", 32'(poll_due), 32'(m_due_vec()));
    check("ms_lt_addr_hold", 32'(ms_lt_addr), 32'(m_out_lt));
    check("txpktype_hold", 32'(txpktype), 32'(m_out_type));
  endtask

  initial begin
    int r;
    for (int n = 0; n < 8; n++) m_cnt[n] = 0;
    regi_packet_type = 4'hA;
    regi_max_retx = 4'd2;
    repeat (3) @(posedge clk_6M);
    #1;
    check("reset_ms_lt_addr", 32'(ms_lt_addr), 32'd0);
    check("reset_ms_txcmd_p", 32'(ms_txcmd_p), 32'd0);
    check("reset_txpktype", 32'(txpktype), 32'd0);
    check("reset_poll_due", 32'(poll_due), 32'd0);
    check("reset_flush_p", 32'(flush_p), 32'd0);
    rstz = 1'b1;

    // Round-robin data: LT1, LT2, LT1.
    regi_isMaster = 1'b1;
    regi_lt_active = 8'h06;
    regi_txdata_pend = 8'h06;
    srcFLOW = 8'hFF;
    dec_arqn = 8'hFF;
    repeat (3) do_slot(1'b0, 1'b0);

    // NAK on LT1 forces a retransmission, ACK lets LT2 through.
    dec_arqn = 8'h00;
    do_slot(1'b0, 1'b0);
    dec_arqn = 8'hFF;
    do_slot(1'b0, 1'b0);

    // Flow stop on the only pending LT, then release it.
    regi_txdata_pend = 8'h04;
    srcFLOW = 8'hFB;
    do_slot(1'b0, 1'b0);
    srcFLOW = 8'hFF;
    do_slot(1'b0, 1'b0);

    // Polling on an idle link.
    do_conn();
    regi_txdata_pend = 8'h00;
    regi_lt_active = 8'h02;
    regi_tpoll = 3'd3;
    repeat (5) do_slot(1'b0, 1'b0);

    // SCO-reserved slot, new connection during ARB, mastership lost during ARB.
    regi_tpoll = '0;
    regi_lt_active = 8'h06;
    regi_txdata_pend = 8'h06;
    sco_reserved = 1'b1;
    do_slot(1'b0, 1'b0);
    sco_reserved = 1'b0;
    do_slot(1'b1, 1'b0);
    do_slot(1'b0, 1'b0);
    do_slot(1'b0, 1'b1);
    do_slot(1'b0, 1'b0);

    // Persistent NAK on LT1 against a retry limit of 2.
    do_conn();
    do_slot(1'b0, 1'b0);
    dec_arqn = 8'h00;
    repeat (4) do_slot(1'b0, 1'b0);
    dec_arqn = 8'hFF;

    for (int s = 0; s < 220; s++) begin
      regi_lt_active   = 8'($urandom());
      regi_txdata_pend = 8'($urandom());
      srcFLOW          = 8'($urandom() | $urandom());
      dec_arqn         = ((s % 16) < 8) ? 8'($urandom() | $urandom()) : 8'($urandom() & $urandom());
      regi_packet_type = 4'($urandom());
      regi_tpoll       = TPOLL_W'($urandom_range(0, 7));
      regi_max_retx    = RETX_W'($urandom_range(0, 3));
      sco_reserved     = ($urandom_range(0, 7) == 0);
      regi_isMaster    = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 29);
      if (r == 0) do_conn();
      do_slot(r == 1, (r == 2) && regi_isMaster);
    end

    repeat (5) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acl_tx_sched.md
Name: acl_tx_sched

Overview:
Master-side ACL transmit scheduler. Chooses which LT_ADDR the master addresses in each master TX slot: ARQ retransmissions first, then round-robin data, then overdue polls. Drives ms_lt_addr / ms_txcmd_p / txpktype to the link controller and the ARQ/flow-control block. Uses that block's srcFLOW and the received ARQN bits.

Parameters:
TPOLL_W, 16, width of the per-LT poll interval counters (slots).
RETX_W, 4, width of the retransmission counter (used only with ACL_RETX_LIMIT_EN).

Ports:
clk_6M  input  1  system clock, 6 MHz
rstz  input  1  asynchronous active-low reset
regi_isMaster  input  1  scheduler enabled only when 1
ms_tslot_p  input  1  one-cycle pulse at master TX slot start
connsnewmaster  input  1  new-connection pulse; clears scheduling state
sco_reserved  input  1  current slot reserved for SCO/eSCO; level sampled at ms_tslot_p
regi_lt_active  input  8  bit n = LT_ADDR n connected; bit 0 ignored
regi_txdata_pend  input  8  bit n = host ACL data queued for LT n
regi_packet_type  input  4  packet type used for data transmissions
regi_tpoll  input  TPOLL_W  poll interval in master slots; 0 disables polling
regi_max_retx  input  RETX_W  retry limit (only with ACL_RETX_LIMIT_EN)
srcFLOW  input  8  per-LT flow bit, 1 = GO
dec_arqn  input  8  received ARQN per LT, 1 = ACK
ms_lt_addr  output  3  selected LT_ADDR
ms_txcmd_p  output  1  one-cycle tx start pulse
txpktype  output  4  packet type for this tx
poll_due  output  8  per-LT poll-overdue flags
flush_p  output  1  one-cycle flush request (only with ACL_RETX_LIMIT_EN; tied 0 otherwise)

Behaviour:
- Reset (rstz low, async): FSM = IDLE, ms_lt_addr = 0, ms_txcmd_p = 0, txpktype = 4'h0, poll_due = 0, flush_p = 0, rr_ptr = 1, last_lt = 0, last_data = 0, all poll counters = 0.
- FSM IDLE -> ARB on ms_tslot_p & regi_isMaster & !sco_reserved. Otherwise stay in IDLE.
- ARB (1 cycle) computes the selection and goes to ISSUE, or to IDLE if nothing qualifies.
- ISSUE (1 cycle) registers ms_lt_addr and txpktype, pulses ms_txcmd_p, then returns to IDLE.
- Latency: ms_tslot_p at cycle N gives ms_txcmd_p at N+2. ms_lt_addr and txpktype are valid from N+2 and hold until the next issue.
- Selection priority in ARB:
  1. Retransmit: last_data=1 & dec_arqn[last_lt]=0 & regi_lt_active[last_lt]. Select last_lt, txpktype = regi_packet_type.
  2. Data: first LT n (1..7) scanning circularly from rr_ptr with active & txdata_pend & srcFLOW[n]. txpktype = regi_packet_type. rr_ptr <= n+1, wrapping 7 -> 1.
  3. Poll: first LT with poll_due[n], scanning circularly from rr_ptr. txpktype = 4'h1 (POLL). rr_ptr is unchanged.
  4. None: no pulse, and all outputs hold.
- last_data is set when an issued packet is data (priority 1 or 2) and cleared when a POLL is issued. last_lt <= the selected LT.
- Poll counters, per active LT:
  - Increment on each ms_tslot_p, saturating at all-ones.
  - Clear to 0 when that LT is issued any packet.
  - poll_due[n] = active[n] & (regi_tpoll != 0) & (cnt[n] >= regi_tpoll).
  - Inactive LT: counter held at 0.
- regi_isMaster falling in ARB/ISSUE: go to IDLE next cycle with no ms_txcmd_p.
- ms_tslot_p arriving in ARB or ISSUE is ignored.
- connsnewmaster has priority over all other updates. It sets FSM = IDLE, rr_ptr = 1, last_data = 0, clears all poll counters and the retry counter, and suppresses any pending pulse.
- sco_reserved=1 at ms_tslot_p: no issue. Poll counters still increment.

Optional Feature:
ACL_RETX_LIMIT_EN.
- Defined:
  - RETX_W-bit retry counter. Incremented on each priority-1 issue; cleared on any priority-2 issue or a POLL issue.
  - When priority 1 qualifies and counter == regi_max_retx: flush_p pulses in ARB, the retransmission is dropped (last_data = 0, counter = 0), and selection continues at priority 2 in the same ARB cycle.
  - regi_max_retx = 0 means unlimited retries.
- Undefined: retries are unlimited, flush_p is tied 0, and regi_max_retx is unused.

Test Plan:
1. Reset, isMaster=1, active=8'h06, pend=8'h06, srcFLOW=8'hff, ms_tslot_p at N -> ms_txcmd_p at N+2, ms_lt_addr=1, txpktype=regi_packet_type. Next slot selects LT 2, next LT 1 (round-robin).
2. Issue data to LT 1, then dec_arqn=8'h00 at the next slot -> LT 1 is re-addressed even though LT 2 is pending. dec_arqn[1]=1 -> LT 2 is selected.
3. srcFLOW[2]=0 with pend=8'h04 only, tpoll=0 -> no ms_txcmd_p. Raise srcFLOW[2]=1 -> LT 2 is issued in the next slot.
4. pend=0, tpoll=3, active=8'h02 -> poll_due[1] rises after 3 slots, a POLL (4'h1) to LT 1 follows, the counter clears and poll_due[1] drops.
5. sco_reserved=1 at the slot, and separately connsnewmaster during ARB -> no pulse in either case. After connsnewmaster, rr_ptr=1 and poll_due=0.
6. With ACL_RETX_LIMIT_EN, max_retx=2 and persistent NAK on LT 1 -> two retransmissions, then flush_p pulses at the third slot and pending LT 2 is issued in that slot.
